// File: rtl/fetch_pc_pkg.sv
// fetch_pc_pkg -- shared CPU constants: next-PC select encoding, reset PC, nop.
// Rev 1.0
`default_nettype none

package fetch_pc_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_if.sv
// fetch_pc_if -- fetch-stage bus between the pipeline/hazard logic and the PC/F-D registers.
// Rev 1.0
`default_nettype none

interface fetch_pc_if;
  import fetch_pc_pkg::*;

  logic        stall;
  npc_op_e     npc_op;
  logic        cmp_out;
  logic [31:0] d_rs;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;
  logic        d_valid;
  logic        jr_misalign;

  modport master (
    output stall, npc_op, cmp_out, d_rs, f_instr,
    input  f_pc, d_instr, d_pc, d_pc8, d_valid, jr_misalign
  );

  modport slave (
    input  stall, npc_op, cmp_out, d_rs, f_instr,
    output f_pc, d_instr, d_pc, d_pc8, d_valid, jr_misalign
  );

endinterface

`default_nettype wire

// File: rtl/fetch_pc_npc.sv
// npc -- combinational next-PC selection for the fetch stage.
// Rev 1.0
`default_nettype none

module npc
  import fetch_pc_pkg::*;
(
  input  logic [31:0] f_pc_i,
  input  logic [31:0] d_pc_i,
  input  logic [25:0] d_instr_i,
  input  logic [31:0] d_rs_i,
  input  logic        d_valid_i,
  input  npc_op_e     npc_op_i,
  input  logic        cmp_out_i,
  output logic [31:0] npc_o,
  output logic        jr_misalign_o
);

  npc_op_e     w_op;
  logic [31:0] w_seq;
  logic [31:0] w_br_off;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;

  // A reset bubble in D carries no control transfer.
  assign w_op     = d_valid_i ? npc_op_i : NPC_SEQ;
  assign w_seq    = f_pc_i + 32'd4;
  assign w_br_off = {{14{d_instr_i[15]}}, d_instr_i[15:0], 2'b00};
  assign w_br_tgt = d_pc_i + 32'd4 + w_br_off;
  assign w_j_tgt  = {d_pc_i[31:28], d_instr_i[25:0], 2'b00};

  always_comb begin
    npc_o = w_seq;
    case (w_op)
      NPC_SEQ: npc_o = w_seq;
      NPC_BR:  npc_o = cmp_out_i ? w_br_tgt : w_seq;
      NPC_J:   npc_o = w_j_tgt;
      NPC_JR:  npc_o = d_rs_i;
      default: npc_o = w_seq;
    endcase
  end

  assign jr_misalign_o = (w_op == NPC_JR) && (d_rs_i[1:0] != 2'b00);

endmodule

`default_nettype wire

// File: rtl/fetch_pc.sv
// fetch_pc -- PC register and F/D pipeline register with one architectural delay slot.
// Rev 1.0
`default_nettype none

module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  fetch_pc_if.slave  bus
);

  logic [31:0] f_pc_q,    f_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q,    d_pc_d;
  logic        d_valid_q, d_valid_d;
  logic        jr_mis_q,  jr_mis_d;

  logic [31:0] w_npc;
  logic        w_jr_mis;

  npc u_npc (
    .f_pc_i        (f_pc_q),
    .d_pc_i        (d_pc_q),
    .d_instr_i     (d_instr_q[25:0]),
    .d_rs_i        (bus.d_rs),
    .d_valid_i     (d_valid_q),
    .npc_op_i      (bus.npc_op),
    .cmp_out_i     (bus.cmp_out),
    .npc_o         (w_npc),
    .jr_misalign_o (w_jr_mis)
  );

  // Under stall the transfer stays in D and is re-evaluated next cycle.
  always_comb begin
    f_pc_d    = f_pc_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    d_valid_d = d_valid_q;
    jr_mis_d  = jr_mis_q;
    if (!bus.stall) begin
      f_pc_d    = w_npc;
      d_instr_d = bus.f_instr;
      d_pc_d    = f_pc_q;
      d_valid_d = 1'b1;
      jr_mis_d  = jr_mis_q | w_jr_mis;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_pc_q    <= RESET_PC;
      d_instr_q <= NOP_INSTR;
      d_pc_q    <= RESET_PC;
      d_valid_q <= 1'b0;
      jr_mis_q  <= 1'b0;
    end else begin
      f_pc_q    <= f_pc_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
      d_valid_q <= d_valid_d;
      jr_mis_q  <= jr_mis_d;
    end
  end

  assign bus.f_pc        = f_pc_q;
  assign bus.d_instr     = d_instr_q;
  assign bus.d_pc        = d_pc_q;
  assign bus.d_pc8       = d_pc_q + 32'd8;
  assign bus.d_valid     = d_valid_q;
  assign bus.jr_misalign = jr_mis_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc -- directed fetch sequence checked against a reference model and literal values.
// Rev 1.0
`default_nettype none

module tb_fetch_pc;
  import fetch_pc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;
  logic mon_en = 1'b0;

  fetch_pc_if bus();

  fetch_pc #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_3010: imem = 32'h1000_FFFC;
      32'h0000_3020: imem = 32'h0800_0C40;
      default:       imem = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign bus.f_instr = imem(bus.f_pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: architectural fetch state derived from the pipeline rules.
  logic [31:0] m_fpc, m_dinstr, m_dpc;
  logic        m_valid, m_mis;

  function automatic logic [31:0] model_next(
    input logic [31:0] fpc, input logic [31:0] dpc, input logic [31:0] di,
    input logic vld, input logic [1:0] op, input logic cmp, input logic [31:0] rs);
    int signed imm;
    imm = $signed(di[15:0]);
    if (!vld) return fpc + 32'd4;
    case (op)
      2'd1:    return cmp ? dpc + 32'd4 + 32'(imm * 4) : fpc + 32'd4;
      2'd2:    return {dpc[31:28], 28'd0} + {4'd0, di[25:0], 2'd0};
      2'd3:    return rs;
      default: return fpc + 32'd4;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fpc    <= 32'h0000_3000;
      m_dinstr <= 32'h0;
      m_dpc    <= 32'h0000_3000;
      m_valid  <= 1'b0;
      m_mis    <= 1'b0;
    end else if (!bus.stall) begin
      m_fpc    <= model_next(m_fpc, m_dpc, m_dinstr, m_valid, bus.npc_op, bus.cmp_out, bus.d_rs);
      m_dinstr <= imem(m_fpc);
      m_dpc    <= m_fpc;
      m_valid  <= 1'b1;
      if (m_valid && bus.npc_op == NPC_JR && bus.d_rs[1:0] != 2'b00) m_mis <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mdl_f_pc",    bus.f_pc,    m_fpc);
      chk("mdl_d_instr", bus.d_instr, m_dinstr);
      chk("mdl_d_pc",    bus.d_pc,    m_dpc);
      chk("mdl_d_pc8",   bus.d_pc8,   m_dpc + 32'd8);
      chk("mdl_d_valid", {31'd0, bus.d_valid},     {31'd0, m_valid});
      chk("mdl_jr_mis",  {31'd0, bus.jr_misalign}, {31'd0, m_mis});
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_f_pc"},    bus.f_pc,    32'h0000_3000);
    chk({tag, "_d_instr"}, bus.d_instr, 32'h0);
    chk({tag, "_d_pc"},    bus.d_pc,    32'h0000_3000);
    chk({tag, "_d_valid"}, {31'd0, bus.d_valid},     32'd0);
    chk({tag, "_jr_mis"},  {31'd0, bus.jr_misalign}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b1;
    bus.stall   = 1'b0;
    bus.npc_op  = NPC_SEQ;
    bus.cmp_out = 1'b0;
    bus.d_rs    = 32'h0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_reset("rst");
    mon_en = 1'b1;

    // Bubble in D: a misaligned JR request must be ignored.
    rst_n       = 1'b1;
    bus.npc_op  = NPC_JR;
    bus.d_rs    = 32'h0000_1233;
    bus.cmp_out = 1'b1;
    step(1);
    chk("rel_f_pc",    bus.f_pc,    32'h0000_3004);
    chk("rel_d_pc",    bus.d_pc,    32'h0000_3000);
    chk("rel_d_instr", bus.d_instr, 32'hC0DE_3000);
    chk("rel_d_valid", {31'd0, bus.d_valid}, 32'd1);
    chk("rel_jr_mis",  {31'd0, bus.jr_misalign}, 32'd0);

    // cmp_out high but op is SEQ: ignored.
    bus.npc_op = NPC_SEQ;
    step(4);
    chk("pre_br_d_pc", bus.d_pc, 32'h0000_3010);

    bus.npc_op = NPC_BR; bus.cmp_out = 1'b1;
    step(1);
    chk("br_t_f_pc", bus.f_pc, 32'h0000_3004);
    chk("br_t_slot", bus.d_pc, 32'h0000_3014);

    bus.npc_op = NPC_SEQ; bus.cmp_out = 1'b0;
    step(4);
    chk("pre_nt_d_pc", bus.d_pc, 32'h0000_3010);
    bus.npc_op = NPC_BR; bus.cmp_out = 1'b0;
    step(1);
    chk("br_nt_f_pc", bus.f_pc, 32'h0000_3018);
    chk("br_nt_d_pc", bus.d_pc, 32'h0000_3014);

    bus.npc_op = NPC_SEQ;
    step(3);
    chk("j_d_pc",  bus.d_pc,  32'h0000_3020);
    chk("j_d_pc8", bus.d_pc8, 32'h0000_3028);
    bus.npc_op = NPC_J; bus.cmp_out = 1'b1;
    step(1);
    chk("j_f_pc",  bus.f_pc, 32'h0000_3100);
    chk("j_slot",  bus.d_pc, 32'h0000_3024);

    bus.npc_op = NPC_SEQ; bus.cmp_out = 1'b0;
    step(1);
    // JR held under stall while d_rs settles.
    bus.npc_op = NPC_JR; bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.d_rs = (i == 0) ? 32'h0 : (i == 1) ? 32'h0000_3101 : 32'h0000_3200;
      step(1);
      chk("stl_f_pc",    bus.f_pc,    32'h0000_3104);
      chk("stl_d_pc",    bus.d_pc,    32'h0000_3100);
      chk("stl_d_instr", bus.d_instr, 32'hC0DE_3100);
      chk("stl_jr_mis",  {31'd0, bus.jr_misalign}, 32'd0);
    end
    bus.stall = 1'b0;
    step(1);
    chk("jr_f_pc", bus.f_pc, 32'h0000_3200);
    chk("jr_slot", bus.d_pc, 32'h0000_3104);

    bus.npc_op = NPC_SEQ;
    step(1);
    bus.npc_op = NPC_JR; bus.d_rs = 32'h0000_3202;
    step(1);
    chk("mis_f_pc", bus.f_pc, 32'h0000_3202);
    chk("mis_flag", {31'd0, bus.jr_misalign}, 32'd1);
    bus.npc_op = NPC_SEQ;
    step(1);
    chk("mis_sticky", {31'd0, bus.jr_misalign}, 32'd1);

    // Address wrap on d_pc8 and f_pc.
    bus.npc_op = NPC_JR; bus.d_rs = 32'hFFFF_FFF8;
    step(1);
    bus.npc_op = NPC_SEQ;
    step(1);
    chk("wrap_d_pc8", bus.d_pc8, 32'h0000_0000);
    step(1);
    chk("wrap_f_pc",  bus.f_pc,  32'h0000_0000);
    chk("wrap_mis",   {31'd0, bus.jr_misalign}, 32'd1);

    // Reset in the middle of a stalled redirect.
    bus.npc_op = NPC_JR; bus.d_rs = 32'h0000_4000; bus.stall = 1'b1;
    step(1);
    #2 rst_n = 1'b0;
    #1 chk_reset("async");
    @(negedge clk);
    rst_n = 1'b1; bus.stall = 1'b0; bus.npc_op = NPC_SEQ;
    step(1);
    chk("rel2_f_pc",    bus.f_pc, 32'h0000_3004);
    chk("rel2_d_pc",    bus.d_pc, 32'h0000_3000);
    chk("rel2_d_valid", {31'd0, bus.d_valid}, 32'd1);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, giving the PC value loaded on reset.
REQ-002 SHALL have ports `clk  in  1`: the single clock, rising edge.
REQ-003 SHALL have port `rst_n  in  1`: reset, asynchronous, active-low.
REQ-004 SHALL have port `stall  in  1`: hazard-unit hold for the F stage and the F/D register.
REQ-005 SHALL have port `npc_op  in  2`: D-stage next-PC select.
REQ-006 SHALL have port `cmp_out  in  1`: branch condition from the D-stage comparator.
REQ-007 SHALL have port `d_rs  in  32`: forwarded GPR[rs] for jr.
REQ-008 SHALL have port `f_instr  in  32`: instruction-memory read data at f_pc.
REQ-009 SHALL have port `f_pc  out  32`: current fetch address, driven to instruction memory.
REQ-010 SHALL have port `d_instr  out  32`: instruction held in the F/D register.
REQ-011 SHALL have port `d_pc  out  32`: PC of d_instr.
REQ-012 SHALL have port `d_pc8  out  32`: d_pc + 8, the link value.
REQ-013 SHALL have port `d_valid  out  1`: d_instr is a real fetched instruction, not a reset bubble.
REQ-014 SHALL have port `jr_misalign  out  1`: sticky flag, set when a jr target has bits [1:0] != 0.

Function
REQ-015 SHALL encode npc_op as follows.
- 00 = SEQ: sequential fetch.
- 01 = BR: conditional branch, taken when cmp_out = 1.
- 10 = J: j/jal.
- 11 = JR.
REQ-016 SHALL use d_instr[15:0] as the branch immediate, sign-extended, shifted left 2, and added to d_pc + 4 (modulo 2^32).
REQ-017 SHALL form the J target as {d_pc[31:28], d_instr[25:0], 2'b00}.
REQ-018 SHALL form the JR target as d_rs, used unmodified.
REQ-019 SHALL compute next PC as follows.
- SEQ: f_pc + 4.
- BR with cmp_out = 0: f_pc + 4.
- BR with cmp_out = 1: branch target.
- J: J target.
- JR: JR target.
REQ-020 SHALL implement one architectural delay slot: the instruction fetched in the cycle the control transfer is in D enters D normally and is never squashed.
REQ-021 SHALL, on each rising edge with stall = 0, load f_pc with next PC and load the F/D register with d_instr = f_instr, d_pc = f_pc, d_valid = 1.
REQ-022 SHALL, with stall = 1, hold f_pc, d_instr, d_pc and d_valid unchanged.
REQ-023 SHALL treat a pending redirect under stall as not lost: the control transfer stays in D and is re-evaluated each cycle with the current cmp_out and d_rs until stall drops.
REQ-024 SHALL apply priority reset > stall > redirect > sequential.
REQ-025 SHALL compute d_pc8 combinationally from d_pc, with wrap-around modulo 2^32.
REQ-026 SHALL set jr_misalign on an unstalled edge where npc_op = JR and d_rs[1:0] != 0; the misaligned target is still loaded.
REQ-027 SHALL clear jr_misalign only by reset.
REQ-028 SHALL ignore cmp_out when npc_op != BR.
REQ-029 SHALL ignore npc_op, cmp_out and d_rs when d_valid = 0, selecting SEQ.
REQ-030 SHALL have f_pc to instruction-memory latency of 0: f_instr is combinational for the current f_pc.

Reset
REQ-031 SHALL, while rst_n = 0, asynchronously force the following.
- f_pc = RESET_PC.
- d_instr = 32'h0000_0000 (nop).
- d_pc = RESET_PC.
- d_valid = 0.
- jr_misalign = 0.
REQ-032 SHALL, on the first rising edge after rst_n rises with stall = 0, fetch RESET_PC into D and set f_pc = RESET_PC + 4.
REQ-033 SHALL make reset asserted mid-stall or mid-redirect discard all pending state.

Structure
REQ-034 SHALL take the npc_op encodings, RESET_PC default and nop constant from the shared CPU package, which also serves the comparator and decoder.
REQ-035 SHALL split next-PC arithmetic into a combinational sub-module `npc`; the PC register and F/D register stay in fetch_pc.

Verification
REQ-036 Reset release: rst_n 0->1, stall = 0, f_instr = X1 -> cycle 1: f_pc = 0x3004, d_pc = 0x3000, d_valid = 1, d_instr = X1.
REQ-037 Taken branch: d_pc = 0x3010, imm = 0xFFFC, BR, cmp_out = 1 -> f_pc becomes 0x3004; delay-slot instruction at 0x3014 reaches D.
REQ-038 Not-taken branch: same stimulus with cmp_out = 0 -> f_pc = f_pc + 4.
REQ-039 J: d_pc = 0x3020, index = 0x0000C40 -> f_pc = 0x0000_3100; d_pc8 = 0x3028.
REQ-040 Stall during JR: stall = 1 for 3 cycles while d_rs changes 0x0->0x3200 -> all state held; first unstalled edge gives f_pc = 0x3200.
REQ-041 Misaligned JR: d_rs = 0x3202 -> f_pc = 0x3202 and jr_misalign = 1, staying 1 until rst_n = 0.
